// File: rtl/serial_frame_ctrl.sv
// Serial byte-to-frame assembler: packs 8 bytes (first byte in the LSBs) into a
// 64-bit frame with ack handshake, flush and idle timeout. Optional statistics under SERIAL_FRAME_STATS_EN.
module serial_frame_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        flush,
    output logic [63:0] frame_out,
    output logic        frame_valid,
    input  logic        frame_ack,
    output logic [3:0]  byte_cnt,
`ifdef SERIAL_FRAME_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [15:0] abort_cnt,
`endif
    output logic        abort
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;

    localparam int            IW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LP_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_byte_cnt;
    logic [63:0]    r_asm;
    logic [63:0]    r_frame_out;
    logic           r_frame_valid;
    logic           r_abort;
    logic [IW-1:0]  r_idle_cnt;

    logic           w_accept;
    logic           w_complete;
    logic           w_ack;
    logic           w_expire;
    logic [63:0]    w_asm_ins;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_accept     = din_valid && (r_state != S_FULL) && !flush;
        w_complete   = w_accept && (r_byte_cnt == 4'd7);
        w_ack        = (r_state == S_FULL) && frame_ack && !flush;
        // An accept on the expiry edge wins over the timeout.
        w_expire     = (TIMEOUT > 0) && (r_state == S_FILL) && (r_idle_cnt == LP_LAST)
                       && !w_accept && !flush;
        w_asm_ins    = r_asm;
        w_asm_ins[{r_byte_cnt[2:0], 3'b000} +: 8] = din;
        w_state_next = r_state;

        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_state_next = S_FILL;
                S_FILL: begin
                    if (w_complete)    w_state_next = S_FULL;
                    else if (w_expire) w_state_next = S_IDLE;
                end
                S_FULL:  if (w_ack) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_byte_cnt    <= 4'd0;
            r_asm         <= 64'd0;
            r_frame_out   <= 64'd0;
            r_frame_valid <= 1'b0;
            r_abort       <= 1'b0;
            r_idle_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_abort       <= w_expire;
            r_frame_valid <= (w_state_next == S_FULL);

            if (w_state_next == S_IDLE)
                r_byte_cnt <= 4'd0;
            else if (w_accept)
                r_byte_cnt <= r_byte_cnt + 4'd1;

            if (w_complete || (w_state_next == S_IDLE))
                r_asm <= 64'd0;
            else if (w_accept)
                r_asm <= w_asm_ins;

            if (w_complete)
                r_frame_out <= w_asm_ins;

            // Counter only advances while a partial frame sits idle.
            if (w_accept || (w_state_next != S_FILL))
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

`ifdef SERIAL_FRAME_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_abort_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= 16'd0;
            r_abort_cnt <= 16'd0;
        end else begin
            if (w_ack)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_expire && (r_abort_cnt != 16'hFFFF))
                r_abort_cnt <= r_abort_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign abort_cnt = r_abort_cnt;
`endif

    assign din_ready   = (r_state != S_FULL);
    assign frame_out   = r_frame_out;
    assign frame_valid = r_frame_valid;
    assign byte_cnt    = r_byte_cnt;
    assign abort       = r_abort;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl: vector table plus hand-written timeout,
// streaming-ack, async-reset and TIMEOUT=0 sequences.
module tb_serial_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  din;
    logic        din_valid;
    logic        din_ready;
    logic        flush;
    logic [63:0] frame_out;
    logic        frame_valid;
    logic        frame_ack;
    logic [3:0]  byte_cnt;
    logic        abort;

    logic [7:0]  d0_din;
    logic        d0_din_valid;
    logic        d0_din_ready;
    logic        d0_flush;
    logic [63:0] d0_frame_out;
    logic        d0_frame_valid;
    logic        d0_frame_ack;
    logic [3:0]  d0_byte_cnt;
    logic        d0_abort;

`ifdef SERIAL_FRAME_STATS_EN
    logic [15:0] frame_cnt, abort_cnt, d0_frame_cnt, d0_abort_cnt;
`endif

    serial_frame_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .flush(flush), .frame_out(frame_out), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .byte_cnt(byte_cnt),
`ifdef SERIAL_FRAME_STATS_EN
        .frame_cnt(frame_cnt), .abort_cnt(abort_cnt),
`endif
        .abort(abort)
    );

    serial_frame_ctrl #(.TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .din(d0_din), .din_valid(d0_din_valid), .din_ready(d0_din_ready),
        .flush(d0_flush), .frame_out(d0_frame_out), .frame_valid(d0_frame_valid),
        .frame_ack(d0_frame_ack), .byte_cnt(d0_byte_cnt),
`ifdef SERIAL_FRAME_STATS_EN
        .frame_cnt(d0_frame_cnt), .abort_cnt(d0_abort_cnt),
`endif
        .abort(d0_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        dv;
        logic [7:0]  din;
        logic        ack;
        logic [3:0]  e_cnt;
        logic        e_rdy;
        logic        e_fv;
        logic [63:0] e_fo;
    } vec_t;

    localparam logic [63:0] F1 = 64'h0807060504030201;
    localparam logic [63:0] F2 = 64'h1716151413121110;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        din       = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    initial begin
        int          n_ab, ab_cyc, idx, nf, bad_run;
        logic        acc, prev_fv;
        logic [63:0] cap [2];
`ifdef SERIAL_FRAME_STATS_EN
        logic [15:0] fc0;
`endif

        reset = 1'b1; din = 8'h00; din_valid = 1'b0; flush = 1'b0; frame_ack = 1'b0;
        d0_din = 8'h00; d0_din_valid = 1'b0; d0_flush = 1'b0; d0_frame_ack = 1'b0;

        //            flush dv    din    ack   cnt    rdy   fv    frame_out
        vq.push_back('{1'b0, 1'b1, 8'h01, 1'b0, 4'd1, 1'b1, 1'b0, 64'h0});
        vq.push_back('{1'b0, 1'b1, 8'h02, 1'b0, 4'd2, 1'b1, 1'b0, 64'h0});
        vq.push_back('{1'b0, 1'b1, 8'h03, 1'b0, 4'd3, 1'b1, 1'b0, 64'h0});
        vq.push_back('{1'b0, 1'b1, 8'h04, 1'b0, 4'd4, 1'b1, 1'b0, 64'h0});
        vq.push_back('{1'b0, 1'b1, 8'h05, 1'b0, 4'd5, 1'b1, 1'b0, 64'h0});
        vq.push_back('{1'b0, 1'b1, 8'h06, 1'b0, 4'd6, 1'b1, 1'b0, 64'h0});
        vq.push_back('{1'b0, 1'b1, 8'h07, 1'b0, 4'd7, 1'b1, 1'b0, 64'h0});
        vq.push_back('{1'b0, 1'b1, 8'h08, 1'b0, 4'd8, 1'b0, 1'b1, F1});
        vq.push_back('{1'b0, 1'b1, 8'hAA, 1'b0, 4'd8, 1'b0, 1'b1, F1});
        vq.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, F1});
        vq.push_back('{1'b0, 1'b1, 8'h11, 1'b1, 4'd1, 1'b1, 1'b0, F1});
        vq.push_back('{1'b0, 1'b1, 8'h22, 1'b0, 4'd2, 1'b1, 1'b0, F1});
        vq.push_back('{1'b0, 1'b1, 8'h33, 1'b0, 4'd3, 1'b1, 1'b0, F1});
        vq.push_back('{1'b0, 1'b1, 8'h44, 1'b0, 4'd4, 1'b1, 1'b0, F1});
        vq.push_back('{1'b0, 1'b1, 8'h55, 1'b0, 4'd5, 1'b1, 1'b0, F1});
        vq.push_back('{1'b1, 1'b1, 8'h66, 1'b0, 4'd0, 1'b1, 1'b0, F1});
        for (int i = 0; i < 7; i++)
            vq.push_back('{1'b0, 1'b1, 8'h10 + 8'(i), 1'b0, 4'(i + 1), 1'b1, 1'b0, F1});
        vq.push_back('{1'b0, 1'b1, 8'h17, 1'b0, 4'd8, 1'b0, 1'b1, F2});
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, F2});

        #3;
        check("async_reset_fo", frame_out, 64'h0);
        #9;
        reset = 1'b0;
        check("rst_cnt", 64'(byte_cnt), 64'd0);
        check("rst_rdy", 64'(din_ready), 64'd1);
        check("rst_fv", 64'(frame_valid), 64'd0);
        check("rst_abort", 64'(abort), 64'd0);

        foreach (vq[i]) begin
            flush = vq[i].flush; din_valid = vq[i].dv; din = vq[i].din; frame_ack = vq[i].ack;
            tick();
            check($sformatf("v%0d_cnt", i), 64'(byte_cnt), 64'(vq[i].e_cnt));
            check($sformatf("v%0d_rdy", i), 64'(din_ready), 64'(vq[i].e_rdy));
            check($sformatf("v%0d_fv", i), 64'(frame_valid), 64'(vq[i].e_fv));
            check($sformatf("v%0d_fo", i), frame_out, vq[i].e_fo);
            check($sformatf("v%0d_abort", i), 64'(abort), 64'd0);
        end
        flush = 1'b0; din_valid = 1'b0; frame_ack = 1'b0;

        // Timeout: abort 16 cycles after the last accept, exactly once.
        send(8'hA1); send(8'hA2); send(8'hA3);
        n_ab = 0; ab_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (abort) begin
                n_ab++;
                if (ab_cyc < 0) ab_cyc = c;
            end
        end
        check("to_cycle", 64'(ab_cyc), 64'd16);
        check("to_pulses", 64'(n_ab), 64'd1);
        check("to_cnt", 64'(byte_cnt), 64'd0);
        check("to_fo", frame_out, F2);
`ifdef SERIAL_FRAME_STATS_EN
        check("to_abort_cnt", 64'(abort_cnt), 64'd1);
`endif

        // Accept on the expiry edge wins.
        send(8'h55);
        n_ab = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (abort) n_ab++;
        end
        send(8'h66);
        if (abort) n_ab++;
        check("race_cnt", 64'(byte_cnt), 64'd2);
        tick();
        if (abort) n_ab++;
        check("race_no_abort", 64'(n_ab), 64'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        check("race_flush_cnt", 64'(byte_cnt), 64'd0);

        // Continuous ack over 16 bytes.
`ifdef SERIAL_FRAME_STATS_EN
        fc0 = frame_cnt;
`endif
        frame_ack = 1'b1; idx = 0; nf = 0; bad_run = 0; prev_fv = 1'b0;
        cap[0] = 64'h0; cap[1] = 64'h0;
        for (int c = 0; c < 30; c++) begin
            din       = 8'h21 + 8'(idx);
            din_valid = (idx < 16);
            acc       = din_valid && din_ready;
            tick();
            if (acc) idx++;
            if (frame_valid) begin
                if (prev_fv) bad_run++;
                if (nf < 2) cap[nf] = frame_out;
                nf++;
            end
            prev_fv = frame_valid;
        end
        frame_ack = 1'b0; din_valid = 1'b0;
        check("ack_bytes", 64'(idx), 64'd16);
        check("ack_frames", 64'(nf), 64'd2);
        check("ack_fv_1cycle", 64'(bad_run), 64'd0);
        check("ack_frame0", cap[0], 64'h2827262524232221);
        check("ack_frame1", cap[1], 64'h302F2E2D2C2B2A29);
`ifdef SERIAL_FRAME_STATS_EN
        check("ack_frame_cnt", 64'(frame_cnt - fc0), 64'd2);
`endif

        // Async reset between edges while FULL.
        for (int i = 0; i < 8; i++) send(8'h81 + 8'(i));
        check("full_fv", 64'(frame_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_fv", 64'(frame_valid), 64'd0);
        check("arst_fo", frame_out, 64'h0);
        check("arst_cnt", 64'(byte_cnt), 64'd0);
        #2 reset = 1'b0;
        send(8'h99);
        check("post_rst_cnt", 64'(byte_cnt), 64'd1);
        check("post_rst_fo", frame_out, 64'h0);

        // TIMEOUT=0 instance never aborts.
        d0_din = 8'h5A; d0_din_valid = 1'b1;
        tick();
        d0_din_valid = 1'b0;
        n_ab = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (d0_abort) n_ab++;
        end
        check("t0_no_abort", 64'(n_ab), 64'd0);
        check("t0_cnt", 64'(d0_byte_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
